// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared depth, loader state encoding and byte-lane helper for imem_loader
package imem_pkg;

  localparam int IMEM_BYTES = 116;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT,
    ST_WR0,
    ST_WR1,
    ST_WR2,
    ST_WR3,
    ST_FIN
  } loader_state_t;

  // Lane 0 is the most significant byte so memory matches the fetch path's read order.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams 32-bit words into byte-wide instruction memory, big-endian
// Optional running word checksum enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      checksum
);

  loader_state_t    state;
  logic [31:0]      addr_q;
  logic [31:0]      word_q;
  logic [CNT_W-1:0] left_q;
  logic             range_bad_q;
  logic [33:0]      end_addr;
  logic             range_bad;
  logic             last_word;

  // 34-bit sum so a base near the top of the address space cannot wrap into range.
  assign end_addr  = {2'b00, base_addr} + {{(34-CNT_W-2){1'b0}}, word_count, 2'b00};
  assign range_bad = end_addr > 34'(MEM_BYTES);
  assign last_word = (left_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      word_q      <= '0;
      left_q      <= '0;
      range_bad_q <= 1'b0;
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b1;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            addr_q      <= base_addr;
            left_q      <= word_count;
            range_bad_q <= range_bad;
            error       <= range_bad;
            busy        <= 1'b1;
            state       <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (range_bad_q) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (left_q == '0) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end else begin
            state    <= ST_WAIT;
            in_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (in_valid && in_ready) begin
            word_q    <= in_data;
            state     <= ST_WR0;
            mem_we    <= 1'b1;
            mem_addr  <= addr_q;
            mem_wdata <= byte_lane(in_data, 2'd0);
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_WR0: begin
          state     <= ST_WR1;
          mem_we    <= 1'b1;
          mem_addr  <= addr_q + 32'd1;
          mem_wdata <= byte_lane(word_q, 2'd1);
        end
        ST_WR1: begin
          state     <= ST_WR2;
          mem_we    <= 1'b1;
          mem_addr  <= addr_q + 32'd2;
          mem_wdata <= byte_lane(word_q, 2'd2);
        end
        ST_WR2: begin
          state     <= ST_WR3;
          mem_we    <= 1'b1;
          mem_addr  <= addr_q + 32'd3;
          mem_wdata <= byte_lane(word_q, 2'd3);
        end
        ST_WR3: begin
          addr_q <= addr_q + 32'd4;
          left_q <= left_q - 1'b1;
          if (last_word) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end else begin
            state    <= ST_WAIT;
            in_ready <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (state == ST_IDLE && start) begin
      sum_q <= '0;
    end else if (state == ST_WAIT && in_valid && in_ready) begin
      sum_q <= sum_q + in_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int MEM = 116;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, mem_we, busy, done, error;
  logic [31:0] mem_addr, checksum;
  logic [7:0]  mem_wdata;

  imem_loader #(.MEM_BYTES(MEM), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tb_mem [MEM];
  logic [31:0] words[$];
  logic [31:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [31:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [31:0] exp_sum;
  bit          exp_rej;
  int done_cnt, err_cnt, done_at, err_at, start_cyc, ready_cycles, overlap;
  bit timeout;

  // Reference: range rule in unbounded arithmetic, bytes MSB-first at ascending addresses.
  function automatic void build_model(input logic [31:0] base, input int cnt);
    longint unsigned end_b;
    end_b = longint'(base) + longint'(4 * cnt);
    exp_addr.delete();
    exp_data.delete();
    exp_sum = 32'd0;
    exp_rej = end_b > longint'(MEM);
    if (!exp_rej) begin
      for (int w = 0; w < cnt; w++) begin
        exp_sum = exp_sum + words[w];
        for (int b = 0; b < 4; b++) begin
          exp_addr.push_back(base + 32'(4 * w + b));
          exp_data.push_back(8'(words[w] >> (8 * (3 - b))));
        end
      end
    end
  endfunction

  task automatic observe();
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (mem_addr < 32'(MEM)) tb_mem[int'(mem_addr)] = mem_wdata;
    end
    if (mem_we && in_ready) overlap++;
    if (in_ready) ready_cycles++;
    if (done) begin done_cnt++; done_at = cyc; end
    if (error) begin err_cnt++; err_at = cyc; end
  endtask

  task automatic do_load(input logic [31:0] base, input int cnt, input int valid_pct, input bit inject_start);
    int idx;
    bit hs, finished;
    wr_addr.delete(); wr_data.delete();
    done_cnt = 0; err_cnt = 0; done_at = -1; err_at = -1;
    ready_cycles = 0; overlap = 0; timeout = 0;
    idx = 0; hs = 0; finished = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = 16'(cnt); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; start_cyc = cyc;
    for (int t = 0; t < 3000 && !finished; t++) begin
      if (t > 0) @(negedge clk);
      if (hs) idx++;
      observe();
      if (done || error) finished = 1;
      start = 1'b0;
      if (!finished && inject_start && busy && $urandom_range(0, 7) == 0) begin
        start = 1'b1; base_addr = $urandom; word_count = 16'($urandom);
      end
      if (!finished && idx < words.size() && $urandom_range(1, 100) <= valid_pct) begin
        in_valid = 1'b1; in_data = words[idx];
      end else begin
        in_valid = 1'b0; in_data = $urandom;
      end
      hs = in_valid && in_ready;
    end
    if (!finished) timeout = 1;
    start = 1'b0; in_valid = 1'b0;
    repeat (3) begin @(negedge clk); observe(); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
    checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL reset_checksum got %h want 0", checksum); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    logic [31:0] want_sum;
    for (int i = 0; i < MEM; i++) tb_mem[i] = 8'h00;
    words = '{32'h20080005, 32'h8C090004};
    do_load(32'd0, 2, 100, 0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b want 0", timeout); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    checks++; if (done_at !== start_cyc + 11) begin errors++; $display("FAIL basic_latency got %0d want %0d", done_at - start_cyc, 11); end
    checks++; if (wr_addr.size() !== 8) begin errors++; $display("FAIL basic_write_count got %0d want 8", wr_addr.size()); end
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== 32'(i) || wr_data[i] !== exp_b[i]) begin
        errors++; $display("FAIL basic_byte%0d got @%h=%h want @%h=%h", i, wr_addr[i], wr_data[i], i, exp_b[i]);
      end
    end
    checks++; if ({tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]} !== 32'h20080005) begin
      errors++; $display("FAIL basic_fetch0 got %h want 20080005", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}); end
    checks++; if ({tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]} !== 32'h8C090004) begin
      errors++; $display("FAIL basic_fetch4 got %h want 8c090004", {tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]}); end
`ifdef IMEM_LOADER_CHECKSUM_EN
    want_sum = words[0] + words[1];
`else
    want_sum = 32'd0;
`endif
    checks++; if (checksum !== want_sum) begin errors++; $display("FAIL basic_checksum got %h want %h", checksum, want_sum); end
  endtask

  task automatic test_boundary();
    words = '{$urandom};
    build_model(32'd112, 1);
    do_load(32'd112, 1, 100, 0);
    checks++; if (err_cnt !== 0 || done_cnt !== 1) begin errors++; $display("FAIL edge_ok_status got err=%0d done=%0d want err=0 done=1", err_cnt, done_cnt); end
    checks++; if (done_at !== start_cyc + 6) begin errors++; $display("FAIL edge_ok_latency got %0d want 6", done_at - start_cyc); end
    checks++; if (wr_addr.size() !== 4) begin errors++; $display("FAIL edge_ok_writes got %0d want 4", wr_addr.size()); end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL edge_ok_byte%0d got @%h=%h want @%h=%h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
    do_load(32'd113, 1, 100, 0);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL edge_bad_error got %0d want 1", err_cnt); end
    checks++; if (err_at !== start_cyc) begin errors++; $display("FAIL edge_bad_error_cycle got %0d want 0", err_at - start_cyc); end
    checks++; if (wr_addr.size() !== 0 || done_cnt !== 0) begin errors++; $display("FAIL edge_bad_writes got writes=%0d done=%0d want 0 0", wr_addr.size(), done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL edge_bad_busy got %b want 0", busy); end
    do_load(32'hFFFF_FFFC, 1, 100, 0);
    checks++; if (err_cnt !== 1 || wr_addr.size() !== 0) begin errors++; $display("FAIL edge_wrap got err=%0d writes=%0d want 1 0", err_cnt, wr_addr.size()); end
  endtask

  task automatic test_zero_count();
    words.delete();
    do_load(32'd8, 0, 100, 0);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", done_cnt); end
    checks++; if (done_at !== start_cyc + 1) begin errors++; $display("FAIL zero_latency got %0d want 1", done_at - start_cyc); end
    checks++; if (ready_cycles !== 0) begin errors++; $display("FAIL zero_in_ready got %0d cycles want 0", ready_cycles); end
    checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL zero_writes got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_valid_toggle();
    words = '{$urandom, $urandom, $urandom};
    build_model(32'd0, 3);
    do_load(32'd0, 3, 50, 0);
    checks++; if (timeout !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL toggle_done got timeout=%b done=%0d want 0 1", timeout, done_cnt); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL toggle_ready_during_write got %0d want 0", overlap); end
    checks++; if (wr_addr.size() !== 12) begin errors++; $display("FAIL toggle_writes got %0d want 12", wr_addr.size()); end
    for (int i = 0; i < 12 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL toggle_byte%0d got @%h=%h want @%h=%h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int cnt;
      logic [31:0] base;
      cnt = $urandom_range(0, 6);
      base = 32'($urandom_range(0, MEM));
      words.delete();
      for (int w = 0; w < cnt; w++) words.push_back($urandom);
      build_model(base, cnt);
      do_load(base, cnt, $urandom_range(30, 100), 1);
      checks++;
      if (timeout !== 1'b0 || err_cnt !== int'(exp_rej) || done_cnt !== int'(!exp_rej)) begin
        errors++; $display("FAIL rand%0d_status got timeout=%b err=%0d done=%0d want rej=%0d", it, timeout, err_cnt, done_cnt, exp_rej);
      end
      checks++;
      if (wr_addr.size() !== exp_addr.size()) begin
        errors++; $display("FAIL rand%0d_writes got %0d want %0d", it, wr_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
        checks++;
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
          errors++; $display("FAIL rand%0d_byte%0d got @%h=%h want @%h=%h", it, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      checks++; if (checksum !== exp_sum) begin errors++; $display("FAIL rand%0d_checksum got %h want %h", it, checksum, exp_sum); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int nwr;
    bit hit;
    words = '{$urandom, $urandom};
    wr_addr.delete(); wr_data.delete();
    nwr = 0; hit = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 32'd0; word_count = 16'd2;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = words[0];
    for (int t = 0; t < 50 && !hit; t++) begin
      @(negedge clk);
      if (mem_we) begin wr_addr.push_back(mem_addr); nwr++; end
      if (nwr == 3) begin hit = 1; reset = 1'b1; end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL midrst_reach_wr2 got %b want 1", hit); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || mem_we !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got busy=%b we=%b rdy=%b done=%b want 0 0 0 0", busy, mem_we, in_ready, done); end
    checks++; if (wr_addr.size() !== 3 || (wr_addr.size() == 3 && wr_addr[2] !== 32'd2)) begin
      errors++; $display("FAIL midrst_partial got %0d writes want 3 ending at 2", wr_addr.size()); end
    reset = 1'b0;
    @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
    words = '{32'h0000_0001, 32'hFFFF_FFFF};
    do_load(32'd0, 2, 100, 0);
    checks++; if (done_cnt !== 1 || checksum !== 32'd0) begin
      errors++; $display("FAIL cksum_wrap got done=%0d sum=%h want 1 00000000", done_cnt, checksum); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_zero_count();
    test_valid_toggle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Sequential writer for the byte-addressed instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes each one as four bytes, big-endian (MSB at the lowest address), one byte per cycle. The byte order matches the `{Mem[a], Mem[a+1], Mem[a+2], Mem[a+3]}` read order of the fetch path. It sits between a host/boot source and the instruction memory's write port, and keeps the pipeline out of fetch while `busy` is high.

## Interface
Parameters:
- `MEM_BYTES`, 116: instruction memory depth in bytes.
- `CNT_W`, 16: width of `word_count`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `base_addr`  in  32  first byte address; sampled with `start`.
- `word_count`  in  CNT_W  number of words to load; sampled with `start`.
- `in_valid`  in  1  `in_data` holds a word.
- `in_ready`  out  1  loader will accept a word this cycle.
- `in_data`  in  32  instruction word.
- `mem_we`  out  1  byte write strobe.
- `mem_addr`  out  32  byte address.
- `mem_wdata`  out  8  byte to write.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `error`  out  1  one-cycle pulse when `start` is rejected.
- `checksum`  out  32  running word sum (see Configuration).

## Operation
- States:
  - IDLE: waiting for `start`.
  - CHECK: range validation.
  - WAIT: waiting for a word.
  - WR0, WR1, WR2, WR3: write one byte each.
  - FIN: completion.
- Start sampling:
  - IDLE + `start`: latch `base_addr` into `addr_q` and `word_count` into `left_q`, clear `checksum`, go to CHECK.
  - `start` in any other state is ignored.
- CHECK:
  - Compute `end = base_addr + 4*word_count` in 34 bits, with no wrap.
  - `end > MEM_BYTES`: pulse `error`, return to IDLE, no writes.
  - `word_count == 0`: go to FIN.
  - Otherwise go to WAIT.
- WAIT:
  - `in_ready = 1`.
  - On `in_valid && in_ready`: latch `in_data` into `word_q`, go to WR0.
  - `in_valid` low: stay in WAIT indefinitely.
- WR0 to WR3:
  - `mem_we = 1`.
  - `mem_wdata` = bytes [31:24], [23:16], [15:8], [7:0] respectively.
  - `mem_addr = addr_q + k` for k = 0..3.
  - WR3 advances `addr_q` by 4 and decrements `left_q`; if `left_q` reaches 0, go to FIN, else go to WAIT.
- FIN: `done = 1` for one cycle, then IDLE.
- `busy` is 1 in every state except IDLE.
- While not writing:
  - `mem_we = 0`.
  - `mem_addr` and `mem_wdata` hold their last values and are don't-care.
- Reset mid-load:
  - Return to IDLE at the next edge.
  - Bytes already written remain in memory.
  - A partially written word is not rolled back.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready`, `mem_we`, `busy`, `done`, `error` are 0.
  - `mem_addr`, `mem_wdata`, `checksum` are 0.
- All outputs are registered state decodes; there is no combinational path from inputs to outputs.
- `start` at edge N: CHECK during cycle N+1. Then either `error` in cycle N+1 (IDLE at N+2), or WAIT/FIN from N+2.
- Per word:
  - 1 accept cycle plus 4 write cycles, so 5 cycles minimum.
  - First `mem_we` is the cycle after the handshake.
- Load latency with `in_valid` held high: `done` is asserted 2 + 5·W cycles after `start`.
- `in_data` must be stable only in the handshake cycle.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - Each accepted word is added mod 2^32 into `checksum`.
  - `checksum` is cleared on `start` and by `reset`.
  - The value is stable from `done` until the next `start`.
- Macro not defined: `checksum` is tied to 0 and no adder is built.

## Structure
- Shared package `imem_pkg`:
  - `IMEM_BYTES` = 116.
  - Loader state enum.
  - Byte-lane select function (word, lane) → byte.
- No sub-module needed; a single flat FSM plus datapath registers.

## Test plan
- Reset, then `start`, `base_addr`=0, `word_count`=2, words 0x20080005, 0x8C090004:
  - Bytes 20 08 00 05 8C 09 00 04 land at addresses 0..7.
  - `done` pulses once.
  - The fetch read at addresses 0 and 4 returns the original words.
- `base_addr`=112, `word_count`=1 (end=116): accepted, bytes at 112..115.
- `base_addr`=113, `word_count`=1 (end=117): `error` pulses, `mem_we` never asserts.
- `word_count`=0: `done` two cycles after `start`, `in_ready` never high.
- `in_valid` toggled 1-0-1 during a 3-word load: `in_ready` only in WAIT, no duplicate or dropped words, contiguous addresses 0..11.
- `reset` asserted during WR2 of word 1: IDLE next cycle, `busy`=0. With `IMEM_LOADER_CHECKSUM_EN`, a clean load of 0x00000001 and 0xFFFFFFFF gives `checksum` 0x00000000.
